// File: rtl/esm_pkg.sv
// Shared constants and helpers for the ESM issue-buffer dependency logic.
package esm_pkg;

    localparam int HAZ_RAW = 0;
    localparam int HAZ_WAR = 1;
    localparam int HAZ_WAW = 2;

    localparam int DEF_BS     = 32;
    localparam int DEF_REGNUM = 16;

    // Width of a register index; a single register still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot mask decoder; register 0 can be made dependency-free.
module reg_onehot_dec
    import esm_pkg::*;
#(
    parameter int REGNUM   = DEF_REGNUM,
    parameter bit ZERO_REG = 1'b1,
    localparam int W       = idx_w(REGNUM)
) (
    input  logic [W-1:0]      idx,
    output logic [REGNUM-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (!(ZERO_REG && (idx == '0))) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/irt_dep_matrix.sv
// Issue-buffer dependency matrix: per-slot register masks plus a row of older
// slots each entry waits on; retiring a slot clears its column (wake-up).
module irt_dep_matrix
    import esm_pkg::*;
#(
    parameter int         BS       = DEF_BS,
    parameter int         REGNUM   = DEF_REGNUM,
    parameter int         NSRC     = 2,
    parameter logic [2:0] HAZ_EN   = 3'b111,
    parameter bit         ZERO_REG = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ins_valid,
    input  logic [$clog2(BS)-1:0]            ins_index,
    input  logic [$clog2(REGNUM)-1:0]        ins_rd,
    input  logic [NSRC*$clog2(REGNUM)-1:0]   ins_rs,
    input  logic                             ret_valid,
    input  logic [$clog2(BS)-1:0]            ret_index,
    input  logic                             flush,
    output logic [0:BS-1]                    ins_dept,
    output logic                             ins_err,
    output logic [0:BS-1]                    entry_valid,
    output logic [0:BS-1]                    ready,
    output logic [$clog2(BS+1)-1:0]          count,
    output logic                             full
);

    localparam int W  = idx_w(REGNUM);
    localparam int IW = $clog2(BS);
    localparam int CW = $clog2(BS+1);

    logic [REGNUM-1:0] rd_mask;
    logic [REGNUM-1:0] rs_oh [NSRC];
    logic [REGNUM-1:0] rs_mask;

    logic [BS-1:0]     valid_q, valid_d;
    logic [REGNUM-1:0] rd_q  [BS];
    logic [REGNUM-1:0] rd_d  [BS];
    logic [REGNUM-1:0] rs_q  [BS];
    logic [REGNUM-1:0] rs_d  [BS];
    logic [BS-1:0]     dep_q [BS];
    logic [BS-1:0]     dep_d [BS];
    logic [CW-1:0]     count_q, count_d;
    logic              ins_err_q, ins_err_d;

    logic [BS-1:0]     dep_row;
    logic              ret_hit_ins;
    logic              ret_eff;
    logic              ins_acc;
    logic              ins_rej;

    reg_onehot_dec #(.REGNUM(REGNUM), .ZERO_REG(ZERO_REG)) u_rd_dec (
        .idx    (ins_rd),
        .onehot (rd_mask)
    );

    for (genvar k = 0; k < NSRC; k++) begin : g_rs_dec
        reg_onehot_dec #(.REGNUM(REGNUM), .ZERO_REG(ZERO_REG)) u_rs_dec (
            .idx    (ins_rs[k*W +: W]),
            .onehot (rs_oh[k])
        );
    end

    always_comb begin
        rs_mask = '0;
        for (int k = 0; k < NSRC; k++) begin
            rs_mask = rs_mask | rs_oh[k];
        end
    end

    // A slot retiring this cycle is already gone from the new row's point of view.
    always_comb begin
        dep_row = '0;
        for (int j = 0; j < BS; j++) begin
            dep_row[j] = valid_q[j]
                       && (IW'(j) != ins_index)
                       && !(ret_valid && (ret_index == IW'(j)))
                       && ((HAZ_EN[HAZ_RAW] && |(rd_q[j] & rs_mask))
                        || (HAZ_EN[HAZ_WAR] && |(rs_q[j] & rd_mask))
                        || (HAZ_EN[HAZ_WAW] && |(rd_q[j] & rd_mask)));
        end
    end

    assign ret_hit_ins = ret_valid && (ret_index == ins_index);
    assign ret_eff     = ret_valid && valid_q[ret_index];
    assign ins_acc     = ins_valid && (!valid_q[ins_index] || ret_hit_ins);
    assign ins_rej     = ins_valid && valid_q[ins_index] && !ret_hit_ins;

    // Retire is applied before insert so a same-slot replace ends up valid.
    always_comb begin
        valid_d   = valid_q;
        count_d   = count_q;
        ins_err_d = ins_rej;
        for (int j = 0; j < BS; j++) begin
            rd_d[j]  = rd_q[j];
            rs_d[j]  = rs_q[j];
            dep_d[j] = dep_q[j];
            if (ret_eff) begin
                dep_d[j][ret_index] = 1'b0;
            end
        end

        if (ret_eff) begin
            valid_d[ret_index] = 1'b0;
            rd_d[ret_index]    = '0;
            rs_d[ret_index]    = '0;
            dep_d[ret_index]   = '0;
        end

        if (ins_acc) begin
            valid_d[ins_index] = 1'b1;
            rd_d[ins_index]    = rd_mask;
            rs_d[ins_index]    = rs_mask;
            dep_d[ins_index]   = dep_row;
        end

        case ({ins_acc, ret_eff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            valid_d   = '0;
            count_d   = '0;
            ins_err_d = 1'b0;
            for (int j = 0; j < BS; j++) begin
                rd_d[j]  = '0;
                rs_d[j]  = '0;
                dep_d[j] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            count_q   <= '0;
            ins_err_q <= 1'b0;
            for (int j = 0; j < BS; j++) begin
                rd_q[j]  <= '0;
                rs_q[j]  <= '0;
                dep_q[j] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            count_q   <= count_d;
            ins_err_q <= ins_err_d;
            for (int j = 0; j < BS; j++) begin
                rd_q[j]  <= rd_d[j];
                rs_q[j]  <= rs_d[j];
                dep_q[j] <= dep_d[j];
            end
        end
    end

    always_comb begin
        ins_dept    = '0;
        entry_valid = '0;
        ready       = '0;
        for (int j = 0; j < BS; j++) begin
            ins_dept[j]    = dep_row[j];
            entry_valid[j] = valid_q[j];
            ready[j]       = valid_q[j] && !(|dep_q[j]);
        end
    end

    assign ins_err = ins_err_q;
    assign count   = count_q;
    assign full    = (count_q == CW'(BS));

endmodule

// File: tb/tb_irt_dep_matrix.sv
// Scoreboard bench for irt_dep_matrix: a full-hazard instance and a RAW-only
// instance share the same stimulus.
module tb_irt_dep_matrix;

    typedef struct packed {
        logic [0:31] v;
        logic [0:31] r;
        logic [5:0]  cnt;
        logic        err;
        logic        full;
    } st_t;

    typedef struct {
        string nm;
        st_t   st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, ins_valid, ret_valid, flush;
    logic [4:0]  ins_index, ret_index;
    logic [3:0]  ins_rd;
    logic [7:0]  ins_rs;

    logic [0:31] dept, ev, rdy;
    logic        err, full;
    logic [5:0]  cnt;
    logic [0:31] dept_r, ev_r, rdy_r;
    logic        err_r, full_r;
    logic [5:0]  cnt_r;

    st_t  obs;
    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    irt_dep_matrix u_dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_index(ins_index),
        .ins_rd(ins_rd), .ins_rs(ins_rs), .ret_valid(ret_valid), .ret_index(ret_index),
        .flush(flush), .ins_dept(dept), .ins_err(err), .entry_valid(ev),
        .ready(rdy), .count(cnt), .full(full)
    );

    irt_dep_matrix #(.HAZ_EN(3'b001)) u_raw (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_index(ins_index),
        .ins_rd(ins_rd), .ins_rs(ins_rs), .ret_valid(ret_valid), .ret_index(ret_index),
        .flush(flush), .ins_dept(dept_r), .ins_err(err_r), .entry_valid(ev_r),
        .ready(rdy_r), .count(cnt_r), .full(full_r)
    );

    always #5 clk = ~clk;

    always_comb obs = '{v: ev, r: rdy, cnt: cnt, err: err, full: full};

    function automatic logic [0:31] sl(input int lo, input int hi);
        logic [0:31] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic st_t mkst(input logic [0:31] v, input logic [0:31] r,
                                 input int c, input logic e, input logic f);
        st_t s;
        s.v = v; s.r = r; s.cnt = 6'(c); s.err = e; s.full = f;
        return s;
    endfunction

    task automatic drive(input bit iv, input int ii, input int rd, input int rs0,
                         input int rs1, input bit rv, input int ri, input bit fl);
        ins_valid = iv;
        ins_index = 5'(ii);
        ins_rd    = 4'(rd);
        ins_rs    = {4'(rs1), 4'(rs0)};
        ret_valid = rv;
        ret_index = 5'(ri);
        flush     = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        drive(1, 0, 3, 1, 2, 1, 4, 1);
        sbq.push_back('{nm: "reset_state", st: mkst('0, '0, 0, 0, 0)});
        tick();
        rst = 1'b0;
        idle();
        #1;
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        drive(1, 0, 3, 3, 3, 0, 0, 0);
        #1;
        checks++;
        if (dept !== 32'h0) begin
            failures++;
            $display("FAIL reset_dept got=%h want=%h", dept, 32'h0);
        end
    endtask

    task automatic test_insert_basic();
        exp_t e;
        do_reset();
        drive(1, 0, 3, 1, 2, 0, 0, 0);
        #1;
        checks++;
        if (dept !== 32'h0) begin
            failures++;
            $display("FAIL basic_dept got=%h want=%h", dept, 32'h0);
        end
        sbq.push_back('{nm: "basic_insert", st: mkst(sl(0, 0), sl(0, 0), 1, 0, 0)});
        tick();
        idle();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
    endtask

    task automatic test_raw_retire();
        exp_t e;
        do_reset();
        drive(1, 0, 3, 1, 2, 0, 0, 0);
        tick();
        drive(1, 1, 5, 3, 0, 0, 0, 0);
        #1;
        checks++;
        if (dept !== sl(0, 0)) begin
            failures++;
            $display("FAIL raw_dept got=%h want=%h", dept, sl(0, 0));
        end
        checks++;
        if (dept_r !== sl(0, 0)) begin
            failures++;
            $display("FAIL raw_dept_rawonly got=%h want=%h", dept_r, sl(0, 0));
        end
        sbq.push_back('{nm: "raw_blocked", st: mkst(sl(0, 1), sl(0, 0), 2, 0, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        sbq.push_back('{nm: "retire_wakeup", st: mkst(sl(1, 1), sl(1, 1), 1, 0, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        // WAW with slot1, but slot1 retires in the same cycle
        drive(1, 2, 5, 0, 0, 1, 1, 0);
        #1;
        checks++;
        if (dept !== 32'h0) begin
            failures++;
            $display("FAIL bypass_dept got=%h want=%h", dept, 32'h0);
        end
        sbq.push_back('{nm: "bypass_state", st: mkst(sl(2, 2), sl(2, 2), 1, 0, 0)});
        tick();
        idle();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
    endtask

    task automatic test_haz_en();
        exp_t e;
        do_reset();
        drive(1, 0, 4, 6, 0, 0, 0, 0);
        sbq.push_back('{nm: "haz_slot0", st: mkst(sl(0, 0), sl(0, 0), 1, 0, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        drive(1, 1, 6, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (dept !== sl(0, 0)) begin
            failures++;
            $display("FAIL war_dept_full got=%h want=%h", dept, sl(0, 0));
        end
        checks++;
        if (dept_r !== 32'h0) begin
            failures++;
            $display("FAIL war_dept_rawonly got=%h want=%h", dept_r, 32'h0);
        end
        sbq.push_back('{nm: "war_state", st: mkst(sl(0, 1), sl(0, 0), 2, 0, 0)});
        tick();
        idle();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        checks++;
        if (rdy_r !== sl(0, 1)) begin
            failures++;
            $display("FAIL war_ready_rawonly got=%h want=%h", rdy_r, sl(0, 1));
        end
    endtask

    task automatic test_ins_err();
        exp_t e;
        do_reset();
        drive(1, 2, 7, 1, 0, 0, 0, 0);
        sbq.push_back('{nm: "err_setup", st: mkst(sl(2, 2), sl(2, 2), 1, 0, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        drive(1, 2, 9, 3, 0, 0, 0, 0);
        sbq.push_back('{nm: "err_reject", st: mkst(sl(2, 2), sl(2, 2), 1, 1, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        // slot2 must still hold rd=7, so a reader of r7 depends on it
        drive(1, 3, 11, 7, 0, 0, 0, 0);
        #1;
        checks++;
        if (dept !== sl(2, 2)) begin
            failures++;
            $display("FAIL err_unchanged_dept got=%h want=%h", dept, sl(2, 2));
        end
        drive(1, 2, 12, 0, 0, 1, 2, 0);
        sbq.push_back('{nm: "replace_same", st: mkst(sl(2, 2), sl(2, 2), 1, 0, 0)});
        tick();
        idle();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
    endtask

    task automatic test_zero_reg_full();
        exp_t e;
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        sbq.push_back('{nm: "zr_slot0", st: mkst(sl(0, 0), sl(0, 0), 1, 0, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        drive(1, 1, 5, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (dept !== 32'h0) begin
            failures++;
            $display("FAIL zr_dept got=%h want=%h", dept, 32'h0);
        end
        sbq.push_back('{nm: "zr_slot1", st: mkst(sl(0, 1), sl(0, 1), 2, 0, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        for (int i = 2; i < 32; i++) begin
            drive(1, i, 0, 0, 0, 0, 0, 0);
            sbq.push_back('{nm: $sformatf("fill_%0d", i),
                            st: mkst(sl(0, i), sl(0, i), i + 1, 0, (i == 31))});
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e.st) begin
                failures++;
                $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
            end
        end
        drive(1, 5, 2, 0, 0, 0, 0, 0);
        sbq.push_back('{nm: "full_reject", st: mkst(sl(0, 31), sl(0, 31), 32, 1, 1)});
        tick();
        idle();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
    endtask

    task automatic test_flush();
        exp_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, i, i + 1, 0, 0, 0, 0, 0);
            sbq.push_back('{nm: $sformatf("pre_flush_%0d", i),
                            st: mkst(sl(0, i), sl(0, i), i + 1, 0, 0)});
            tick();
            e = sbq.pop_front();
            checks++;
            if (obs !== e.st) begin
                failures++;
                $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
            end
        end
        drive(0, 0, 0, 0, 0, 1, 20, 0);
        sbq.push_back('{nm: "retire_invalid", st: mkst(sl(0, 4), sl(0, 4), 5, 0, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        // insert into valid slot0 alongside flush: dropped, and no error either
        drive(1, 0, 3, 0, 0, 0, 0, 1);
        sbq.push_back('{nm: "flush_state", st: mkst('0, '0, 0, 0, 0)});
        tick();
        idle();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
        sbq.push_back('{nm: "post_flush_idle", st: mkst('0, '0, 0, 0, 0)});
        tick();
        e = sbq.pop_front();
        checks++;
        if (obs !== e.st) begin
            failures++;
            $display("FAIL %s got=%h want=%h", e.nm, obs, e.st);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_insert_basic();
        test_raw_retire();
        test_haz_en();
        test_ins_err();
        test_zero_reg_full();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
